// File: rtl/upg_pkg.sv
// ============================================================================
// Module  : upg_pkg
// Brief   : Shared state encoding and frame constants for the UART word loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package upg_pkg;

  typedef enum logic [2:0] {
    UPG_HDR0 = 3'd0,
    UPG_HDR1 = 3'd1,
    UPG_DATA = 3'd2,
    UPG_CSUM = 3'd3,
    UPG_DONE = 3'd4,
    UPG_ERR  = 3'd5
  } upg_state_e;

  localparam int UPG_HDR_BYTES  = 2;
  localparam int UPG_WORD_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/upg_idle_timer.sv
// ============================================================================
// Module  : upg_idle_timer
// Brief   : Idle-cycle counter; expired flags the cycle in which the
//           TIMEOUT_CYC-th consecutive idle cycle elapses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module upg_idle_timer #(
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int                 c_CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYC);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT_CYC - 1);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear || !enable) begin
      r_cnt <= '0;
    end else if (r_cnt != c_LIMIT) begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  // r_cnt counts completed idle cycles, so the current cycle is the last one at c_LAST
  assign expired = enable && !clear && (r_cnt >= c_LAST);

endmodule

`default_nettype wire

// File: rtl/upg_word_loader.sv
// ============================================================================
// Module  : upg_word_loader
// Brief   : Turns UART bytes (16-bit LE word count, then LE 32-bit words) into
//           ROM word writes. Optional trailing XOR checksum via UPG_CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module upg_word_loader
  import upg_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic              upg_clk_i,
  input  logic              upg_rstn_i,
  input  logic              byte_vld_i,
  input  logic [7:0]        byte_dat_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              upg_err_o
);

  localparam logic [32:0] c_CAPACITY = 33'(1) << ADDR_W;

`ifdef UPG_CHECKSUM_EN
  localparam upg_state_e c_END = UPG_CSUM;
  logic [7:0] r_csum;
`else
  localparam upg_state_e c_END = UPG_DONE;
`endif

  upg_state_e        r_state;
  logic [15:0]       r_n;
  logic [1:0]        r_idx;
  logic [23:0]       r_word;
  logic [ADDR_W-1:0] r_addr;
  logic [16:0]       r_wcnt;
  logic              w_timer_en;
  logic              w_expired;
  logic [15:0]       w_n_hdr;
  logic              w_last_byte;
  logic              w_last_word;

  assign w_timer_en  = (r_state == UPG_HDR1) || (r_state == UPG_DATA) || (r_state == UPG_CSUM);
  assign w_n_hdr     = {byte_dat_i, r_n[7:0]};
  assign w_last_byte = (r_idx == 2'(UPG_WORD_BYTES - 1));
  assign w_last_word = ((r_wcnt + 17'd1) == {1'b0, r_n});

  upg_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk     (upg_clk_i),
    .rst_n   (upg_rstn_i),
    .clear   (byte_vld_i),
    .enable  (w_timer_en),
    .expired (w_expired)
  );

  always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
    if (!upg_rstn_i) begin
      r_state    <= UPG_HDR0;
      r_n        <= '0;
      r_idx      <= '0;
      r_word     <= '0;
      r_addr     <= '0;
      r_wcnt     <= '0;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_done_o <= 1'b0;
      upg_err_o  <= 1'b0;
`ifdef UPG_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      upg_wen_o  <= 1'b0;
      // done follows the state by one cycle so it rises after the last write
      upg_done_o <= (r_state == UPG_DONE);
      case (r_state)
        UPG_HDR0: begin
          if (byte_vld_i) begin
            r_n     <= {8'h00, byte_dat_i};
            r_state <= UPG_HDR1;
`ifdef UPG_CHECKSUM_EN
            r_csum  <= byte_dat_i;
`endif
          end
        end
        UPG_HDR1: begin
          if (byte_vld_i) begin
            r_n <= w_n_hdr;
`ifdef UPG_CHECKSUM_EN
            r_csum <= r_csum ^ byte_dat_i;
`endif
            if ({17'b0, w_n_hdr} > c_CAPACITY) begin
              r_state   <= UPG_ERR;
              upg_err_o <= 1'b1;
            end else if (w_n_hdr == 16'h0000) begin
              r_state <= c_END;
            end else begin
              r_state <= UPG_DATA;
            end
          end else if (w_expired) begin
            r_state   <= UPG_ERR;
            upg_err_o <= 1'b1;
          end
        end
        UPG_DATA: begin
          if (byte_vld_i) begin
            r_idx <= r_idx + 2'd1;
`ifdef UPG_CHECKSUM_EN
            r_csum <= r_csum ^ byte_dat_i;
`endif
            if (w_last_byte) begin
              upg_wen_o <= 1'b1;
              upg_dat_o <= {byte_dat_i, r_word};
              upg_adr_o <= r_addr;
              r_addr    <= r_addr + ADDR_W'(1);
              r_wcnt    <= r_wcnt + 17'd1;
              if (w_last_word) begin
                r_state <= c_END;
              end
            end else begin
              r_word <= {byte_dat_i, r_word[23:8]};
            end
          end else if (w_expired) begin
            r_state   <= UPG_ERR;
            upg_err_o <= 1'b1;
          end
        end
`ifdef UPG_CHECKSUM_EN
        UPG_CSUM: begin
          if (byte_vld_i) begin
            if (byte_dat_i == r_csum) begin
              r_state <= UPG_DONE;
            end else begin
              r_state   <= UPG_ERR;
              upg_err_o <= 1'b1;
            end
          end else if (w_expired) begin
            r_state   <= UPG_ERR;
            upg_err_o <= 1'b1;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_upg_word_loader.sv
// ============================================================================
// Module  : tb_upg_word_loader
// Brief   : Directed self-checking bench for upg_word_loader (TIMEOUT_CYC=16).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_upg_word_loader;

  localparam int ADDR_W      = 14;
  localparam int TIMEOUT_CYC = 16;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              vld = 1'b0;
  logic [7:0]        dat = 8'h00;
  logic              wen;
  logic [ADDR_W-1:0] adr;
  logic [31:0]       wdat;
  logic              done;
  logic              err;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [31:0] wq_adr[$];
  logic [31:0] wq_dat[$];
  int          wq_cyc[$];
  int          byte_cyc[$];
  int          done_cyc = -1;

  upg_word_loader #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .upg_clk_i  (clk),
    .upg_rstn_i (rstn),
    .byte_vld_i (vld),
    .byte_dat_i (dat),
    .upg_wen_o  (wen),
    .upg_adr_o  (adr),
    .upg_dat_o  (wdat),
    .upg_done_o (done),
    .upg_err_o  (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (wen) begin
      wq_adr.push_back(32'(adr));
      wq_dat.push_back(wdat);
      wq_cyc.push_back(cyc);
    end
    if (done && done_cyc < 0) done_cyc = cyc;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    vld  = 1'b0;
    #1;
    check_eq("rst_flags", {29'b0, wen, done, err}, 32'h0);
    check_eq("rst_adr", 32'(adr), 32'h0);
    check_eq("rst_dat", wdat, 32'h0);
    repeat (2) @(negedge clk);
    wq_adr.delete();
    wq_dat.delete();
    wq_cyc.delete();
    byte_cyc.delete();
    done_cyc = -1;
    rstn = 1'b1;
  endtask

  // Bytes on consecutive cycles; byte_cyc records each capture edge
  task automatic send_burst(input logic [7:0] b[$]);
    foreach (b[i]) begin
      @(negedge clk);
      vld = 1'b1;
      dat = b[i];
      byte_cyc.push_back(cyc + 1);
    end
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset values and no timeout while waiting for a header
    do_reset();
    idle(40);
    check_eq("hdr0_no_timeout", {30'b0, done, err}, 32'h0);

    // Two-word frame
    send_burst('{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
    idle(3);
    check_eq("t1_nwr", 32'(wq_adr.size()), 32'd2);
    check_eq("t1_adr0", wq_adr[0], 32'd0);
    check_eq("t1_dat0", wq_dat[0], 32'h12345678);
    check_eq("t1_adr1", wq_adr[1], 32'd1);
    check_eq("t1_dat1", wq_dat[1], 32'hDEADBEEF);
    check_eq("t1_wen_lat", 32'(wq_cyc[0]), 32'(byte_cyc[5]));
    check_eq("t1_done_lat", 32'(done_cyc), 32'(wq_cyc[1] + 1));
    check_eq("t1_flags", {30'b0, done, err}, 32'h2);

    // Empty frame, trailing bytes ignored
    do_reset();
    send_burst('{8'h00, 8'h00});
    idle(2);
    send_burst('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55});
    idle(2);
    check_eq("t2_nwr", 32'(wq_adr.size()), 32'd0);
    check_eq("t2_flags", {30'b0, done, err}, 32'h2);

    // Oversized count rejected
    do_reset();
    send_burst('{8'h01, 8'h40, 8'h78, 8'h56, 8'h34, 8'h12});
    idle(2);
    check_eq("t3_nwr", 32'(wq_adr.size()), 32'd0);
    check_eq("t3_flags", {30'b0, done, err}, 32'h1);

    // Count equal to capacity is accepted
    do_reset();
    send_burst('{8'h00, 8'h40, 8'h78, 8'h56, 8'h34, 8'h12});
    idle(2);
    check_eq("cap_nwr", 32'(wq_adr.size()), 32'd1);
    check_eq("cap_flags", {30'b0, done, err}, 32'h0);

    // Timeout after 16 idle cycles
    do_reset();
    send_burst('{8'h01, 8'h00, 8'hAA});
    repeat (15) @(posedge clk);
    #1;
    check_eq("t4_err_at15", {31'b0, err}, 32'h0);
    @(posedge clk);
    #1;
    check_eq("t4_err_at16", {31'b0, err}, 32'h1);
    check_eq("t4_nwr", 32'(wq_adr.size()), 32'd0);

    // Byte on the 16th idle cycle wins
    do_reset();
    send_burst('{8'h01, 8'h00, 8'hAA});
    repeat (15) @(posedge clk);
    send_burst('{8'hBB});
    #1;
    check_eq("t4b_err", {31'b0, err}, 32'h0);
    send_burst('{8'hCC, 8'hDD});
    idle(2);
    check_eq("t4b_nwr", 32'(wq_adr.size()), 32'd1);
    check_eq("t4b_dat", wq_dat[0], 32'hDDCCBBAA);
    check_eq("t4b_flags", {30'b0, done, err}, 32'h2);

    // Reset mid-word, then a clean frame
    do_reset();
    send_burst('{8'h01, 8'h00, 8'h04, 8'h03});
    do_reset();
    send_burst('{8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01});
    idle(2);
    check_eq("t5_nwr", 32'(wq_adr.size()), 32'd1);
    check_eq("t5_adr", wq_adr[0], 32'd0);
    check_eq("t5_dat", wq_dat[0], 32'h01020304);
    check_eq("t5_flags", {30'b0, done, err}, 32'h2);

`ifdef UPG_CHECKSUM_EN
    do_reset();
    send_burst('{8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h05});
    idle(2);
    check_eq("t6_ok_nwr", 32'(wq_adr.size()), 32'd1);
    check_eq("t6_ok_flags", {30'b0, done, err}, 32'h2);
    do_reset();
    send_burst('{8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01, 8'h06});
    idle(2);
    check_eq("t6_bad_nwr", 32'(wq_adr.size()), 32'd1);
    check_eq("t6_bad_flags", {30'b0, done, err}, 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
